// File: rtl/nibble_add_seq_pkg.sv
// Shared types and helpers for the nibble-serial adder sequencer.
// Optional subtract mode is enabled by defining NIBBLE_ADD_SEQ_SUB_EN.
package nibble_add_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Slice index width; never below one bit so the counter always exists.
    function automatic int idx_width(input int nibbles);
        int w;
        w = $clog2(nibbles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/nibble_add_sequencer.sv
// Wide adder built by sequencing an external 4-bit parallel_adder, LSB slice first.
// Define NIBBLE_ADD_SEQ_SUB_EN to add an op port selecting a - b (op=1).
module nibble_add_sequencer
    import nibble_add_seq_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W      = SLICE_W * NIBBLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic               cin,
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    input  logic               op,
`endif
    output logic               busy,
    output logic               done,
    output logic [W-1:0]       sum,
    output logic               cout,
    output logic [SLICE_W-1:0] add_a,
    output logic [SLICE_W-1:0] add_b,
    output logic               add_cin,
    input  logic [SLICE_W-1:0] add_sum,
    input  logic               add_cout
);

    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     work_q, work_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             first_carry_s;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    logic             op_q, op_d;
`endif

    // Carry injected into the LSB slice for a newly accepted request.
    always_comb begin
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        if (op) begin
            first_carry_s = 1'b1;
        end else begin
            first_carry_s = cin;
        end
`else
        first_carry_s = cin;
`endif
    end

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        op_d    = op_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = first_carry_s;
                    idx_d   = '0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
                    op_d    = op;
`endif
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                work_d[idx_q*SLICE_W +: SLICE_W] = add_sum;
                carry_d = add_cout;
                // Publish the whole result at once so sum never shows a partial mix.
                if (idx_q == LAST_IDX) begin
                    sum_d   = work_d;
                    cout_d  = add_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Slice adder drive; idle and done phases present zeros.
    always_comb begin
        add_a   = {SLICE_W{1'b0}};
        add_b   = {SLICE_W{1'b0}};
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[idx_q*SLICE_W +: SLICE_W];
            add_cin = carry_q;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            if (op_q) begin
                add_b = ~b_q[idx_q*SLICE_W +: SLICE_W];
            end else begin
                add_b = b_q[idx_q*SLICE_W +: SLICE_W];
            end
`else
            add_b = b_q[idx_q*SLICE_W +: SLICE_W];
`endif
        end else begin
            add_a   = {SLICE_W{1'b0}};
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            op_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            op_q    <= op_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/nibble_add_sequencer.md
Name: nibble_add_sequencer

Overview:
Controller that computes a wide add using one external 4-bit parallel_adder slice over several cycles. It latches two wide operands and a carry-in, then presents one 4-bit slice per cycle to the adder, LSB slice first. It chains the carry between slices and collects the partial sums into a wide result. It sits beside the parallel_adder instance and owns all of that adder's inputs.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (default 16); legal range 2..16.

Ports:
clk       input   1    rising-edge clock
rst_n     input   1    synchronous active-low reset
start     input   1    request; sampled only when not busy
a         input   W    operand A, latched on accepted start
b         input   W    operand B, latched on accepted start
cin       input   1    carry into LSB slice, latched on accepted start
busy      output  1    high while a sequence is running
done      output  1    one-cycle pulse when sum/cout are valid
sum       output  W    result; holds until next accepted start
cout      output  1    carry out of MSB slice; holds with sum
add_a     output  4    to adder A
add_b     output  4    to adder B
add_cin   output  1    to adder Carry_in
add_sum   input   4    from adder Sum (combinational return)
add_cout  input   1    from adder Carry_out (combinational return)

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n). All state changes occur on the rising edge of clk.
- Reset values (rst_n=0 at an edge): state=IDLE, busy=0, done=0, sum=0, cout=0, idx=0, internal carry=0, latched operands=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1: latch a, b, cin; idx<=0; carry<=cin; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1.
  - Adder drive (combinational from registers): add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin=carry.
  - Each edge: sum_reg[4*idx+:4]<=add_sum; carry<=add_cout; idx<=idx+1.
  - When idx==NIBBLES-1: write the last slice, cout<=add_cout, go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - start=1 in DONE is accepted, as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start accepted at edge 0. done is high during the cycle after edge NIBBLES. The result is visible NIBBLES cycles after acceptance.
- start while busy is ignored. Operand changes while busy do not affect the result.
- add_a, add_b, add_cin are 0 in IDLE and DONE.
- sum/cout:
  - Hold their previous values while RUN is in progress. Partial slices are written into a separate working register.
  - The working register is copied to sum at the transition to DONE, so sum never shows a mixed result.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(W+1).
- Reset mid-RUN aborts the sequence: no done pulse, outputs cleared to reset values.

Optional Feature:
Macro: NIBBLE_ADD_SEQ_SUB_EN
- Defined:
  - Adds input port op (1 bit), latched with the operands.
  - op=1 computes a - b: add_b = ~b slice; initial carry forced to 1; cin ignored.
  - cout=1 means no borrow (a >= b).
  - op=0 behaves as plain add.
- Undefined:
  - No op port; add only.
  - Logic is identical to the op=0 path.

Decomposition:
- Package nibble_add_seq_pkg:
  - SLICE_W=4.
  - State enum typedef seq_state_t {IDLE, RUN, DONE}.
  - Index width function/constant: clog2(NIBBLES).
- No sub-module. The 4-bit slice adder stays an external parallel_adder instance. The bench wires a real parallel_adder to the add_* ports.

Test Plan:
1. a=0x1234, b=0x1111, cin=0 -> sum=0x2345, cout=0. done pulses exactly 4 cycles after start accepted; busy high for 4 cycles.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all slices). a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
3. Start a=0x0F0F, b=0x0101. Pulse start with a=0xAAAA in RUN cycle 2 -> ignored; result 0x1010, cout=0. A new start in the DONE cycle is accepted, with busy=1 on the next cycle.
4. rst_n=0 during RUN cycle 2 -> next edge: busy=0, done=0, sum=0, cout=0, no done pulse. A following start with a=0x0003, b=0x0004 gives 0x0007.
5. Check sum/cout stability: previous result 0x2345 stays visible throughout the next RUN until the new done.
6. (NIBBLE_ADD_SEQ_SUB_EN) op=1, a=0x0007, b=0x0005 -> sum=0x0002, cout=1. op=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. op=1 with cin=1 -> same results (cin ignored).
